// File: rtl/mpu_host_sequencer.sv
// rtl/mpu_host_sequencer.sv - host-side sequencer that issues MPU instructions and moves LOAD/UNLOAD bursts
module mpu_host_sequencer #(
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_instr,
  output logic       cmd_ready,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic [7:0] host_instruction,
  input  logic       busy,
  output logic [7:0] host_data_out,
  input  logic [7:0] ul_data_in,
  output logic       ul_valid,
  output logic [7:0] ul_data,
  input  logic       ul_ready,
  output logic       err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, ISSUE, STREAM, WAIT_BUSY, WAIT_DONE, DRAIN
  } state_t;

  state_t          state, state_next;
  logic [7:0]      instr;
  logic [CW-1:0]   cnt;
  logic [7:0]      buffer [DEPTH];
  logic [IW-1:0]   cur_idx, prev_idx;
  logic            is_load, is_unload, cmd_nop, cmd_load, advance;

  assign is_load   = (instr[3:0] == 4'b0100);
  assign is_unload = (instr[3:0] == 4'b0110);
  assign cmd_load  = (cmd_instr[3:0] == 4'b0100);
  assign cmd_nop   = (cmd_instr[3:0] == 4'b0000);
  assign cur_idx   = IW'(cnt);
  // Streaming lags the counter by one: cycle T+1 is a bubble, byte k sits at cnt == k+1.
  assign prev_idx  = IW'(cnt - 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next       = state;
    cmd_ready        = 1'b0;
    ld_ready         = 1'b0;
    ul_valid         = 1'b0;
    ul_data          = 8'h00;
    host_instruction = 8'h00;
    host_data_out    = 8'h00;
    err              = 1'b0;
    advance          = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_nop) state_next = cmd_load ? FILL : ISSUE;
      end
      FILL: begin
        ld_ready = 1'b1;
        advance  = ld_valid;
        if (ld_valid && cnt == LAST) state_next = ISSUE;
      end
      ISSUE: begin
        if (!busy) begin
          host_instruction = instr;
          state_next       = (is_load || is_unload) ? STREAM : WAIT_BUSY;
        end
      end
      STREAM: begin
        advance = 1'b1;
        if (is_load && cnt != '0) host_data_out = buffer[prev_idx];
        if (cnt == FULL) state_next = WAIT_DONE;
      end
      WAIT_BUSY: begin
        advance = 1'b1;
        if (busy) state_next = WAIT_DONE;
        else if (cnt == TO_LAST) begin
          err        = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!busy) state_next = is_unload ? DRAIN : IDLE;
      end
      DRAIN: begin
        ul_valid = 1'b1;
        ul_data  = buffer[cur_idx];
        advance  = ul_ready;
        if (ul_ready && cnt == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr <= 8'h00;
      cnt   <= '0;
    end else begin
      if (state == IDLE && cmd_valid) instr <= cmd_instr;
      if (state_next != state) cnt <= '0;
      else if (advance)        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && ld_valid) buffer[cur_idx] <= ld_data;
    if (state == STREAM && is_unload && cnt != '0) buffer[prev_idx] <= ul_data_in;
  end

endmodule
